// File: rtl/i2c_target_pkg.sv
// Shared definitions for the I2C target front end.
// Holds the protocol state encoding, the ACK/NAK bus levels and a
// small helper that decides whether an address byte selects this target.
package i2c_target_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_WR_BYTE,
    ST_WR_ACK,
    ST_RD_LOAD,
    ST_RD_BYTE,
    ST_RD_ACK,
    ST_IGNORE
  } state_t;

  localparam logic I2C_ACK = 1'b0;
  localparam logic I2C_NAK = 1'b1;

  // The upper seven bits of the first byte after START carry the address;
  // bit 0 is the R/W flag and does not take part in the match.
  function automatic logic addr_match(input logic [7:0] addr_byte,
                                      input logic [6:0] addr);
    return addr_byte[7:1] == addr;
  endfunction

endpackage

// File: rtl/i2c_if.sv
// Open-drain I2C bus seen by one agent.
// sda/scl are the resolved bus levels (wired-AND of every agent plus the
// pull-ups, resolved outside this block). An agent never drives a 1: it
// only asserts sda_drive_low/scl_drive_low to pull the line down, and
// leaving them low is the released (Z) condition.
//   scl, sda                     : resolved bus levels
//   scl_drive_low, sda_drive_low : this agent pulls the line to 0
interface i2c_if;
  logic scl;
  logic sda;
  logic scl_drive_low;
  logic sda_drive_low;

  modport target (
    input  scl,
    input  sda,
    output scl_drive_low,
    output sda_drive_low
  );
endinterface

// File: rtl/i2c_line_sync.sv
// Synchronizer and edge detector for one I2C line.
//   clk, rstn : system clock, asynchronous active-low reset
//   line      : raw asynchronous bus level
//   level     : synchronized level
//   rise/fall : one-cycle pulses when the synchronized level changes
// Flops reset to 1 because an idle bus is pulled high, so leaving reset
// does not fabricate an edge.
module i2c_line_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rstn,
  input  logic line,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] chain;
  logic              prev;

  // Shift the raw line through the synchronizer, then keep one extra
  // flop of history so edges can be seen on the settled value.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      chain <= '1;
      prev  <= 1'b1;
    end else begin
      chain <= {chain[STAGES-2:0], line};
      prev  <= chain[STAGES-1];
    end
  end

  assign level = chain[STAGES-1];
  assign rise  = level & ~prev;
  assign fall  = ~level & prev;

endmodule

// File: rtl/i2c_target.sv
// Oversampled I2C target (slave) with a 7-bit address.
//   clk, rstn            : system clock, asynchronous active-low reset
//   i2c                  : open-drain bus (only ever pulls lines low)
//   rx_data/rx_valid     : written byte offered to local logic
//   rx_ready             : local logic consumes rx_data
//   tx_data/tx_valid     : byte supplied by local logic for a read
//   tx_ready             : one-cycle pulse when tx_data is captured
//   rw                   : R/W bit of the current addressed transfer
//   addressed            : set from address ACK until STOP/START
//   master_ack           : controller ACK after the last read byte (1=ACK)
//   stop_det             : one-cycle pulse on any STOP
// Bits are sampled on the synchronized SCL rise; SDA is only changed
// after a synchronized SCL fall. SCL is stretched while a written byte
// cannot be handed over or while no read byte is available.
module i2c_target #(
  parameter logic [6:0] ADDR        = 7'h18,
  parameter int         SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rstn,
  i2c_if.target       i2c,
  output logic [7:0]  rx_data,
  output logic        rx_valid,
  input  logic        rx_ready,
  input  logic [7:0]  tx_data,
  input  logic        tx_valid,
  output logic        tx_ready,
  output logic        rw,
  output logic        addressed,
  output logic        master_ack,
  output logic        stop_det
);

  import i2c_target_pkg::*;

  logic sda_s, sda_rise, sda_fall;
  logic scl_s, scl_rise, scl_fall;
  logic start_det, stop_now;

  state_t     state, state_nx;
  logic [3:0] bit_cnt, bit_cnt_nx;
  logic [7:0] shreg, shreg_nx;
  logic       sda_low, sda_low_nx;
  logic       scl_low, scl_low_nx;
  logic [7:0] rx_data_nx;
  logic       rx_valid_nx, tx_ready_nx, rw_nx;
  logic       addressed_nx, master_ack_nx, stop_det_nx;

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_sda_sync (
    .clk   (clk),
    .rstn  (rstn),
    .line  (i2c.sda),
    .level (sda_s),
    .rise  (sda_rise),
    .fall  (sda_fall)
  );

  i2c_line_sync #(.STAGES(SYNC_STAGES)) u_scl_sync (
    .clk   (clk),
    .rstn  (rstn),
    .line  (i2c.scl),
    .level (scl_s),
    .rise  (scl_rise),
    .fall  (scl_fall)
  );

  // START/STOP need SCL high both before and after the SDA edge. When this
  // block releases a stretched SCL and changes SDA in the same cycle, both
  // edges arrive together and must not be mistaken for a bus condition.
  assign start_det = sda_fall & scl_s & ~scl_rise;
  assign stop_now  = sda_rise & scl_s & ~scl_rise;

  assign i2c.sda_drive_low = sda_low;
  assign i2c.scl_drive_low = scl_low;

  // State and datapath registers; everything resets to the released,
  // idle condition so a reset mid-transfer frees the bus at once.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state      <= ST_IDLE;
      bit_cnt    <= '0;
      shreg      <= '0;
      sda_low    <= 1'b0;
      scl_low    <= 1'b0;
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      tx_ready   <= 1'b0;
      rw         <= 1'b0;
      addressed  <= 1'b0;
      master_ack <= 1'b0;
      stop_det   <= 1'b0;
    end else begin
      state      <= state_nx;
      bit_cnt    <= bit_cnt_nx;
      shreg      <= shreg_nx;
      sda_low    <= sda_low_nx;
      scl_low    <= scl_low_nx;
      rx_data    <= rx_data_nx;
      rx_valid   <= rx_valid_nx;
      tx_ready   <= tx_ready_nx;
      rw         <= rw_nx;
      addressed  <= addressed_nx;
      master_ack <= master_ack_nx;
      stop_det   <= stop_det_nx;
    end
  end

  // Protocol sequencing. The bit counter counts SCL rises within a byte;
  // in the ACK states it only marks that the 9th clock has been seen so
  // the following fall can end the ACK slot.
  always_comb begin
    state_nx      = state;
    bit_cnt_nx    = bit_cnt;
    shreg_nx      = shreg;
    sda_low_nx    = sda_low;
    scl_low_nx    = scl_low;
    rx_data_nx    = rx_data;
    rx_valid_nx   = rx_valid;
    tx_ready_nx   = 1'b0;
    rw_nx         = rw;
    addressed_nx  = addressed;
    master_ack_nx = master_ack;
    stop_det_nx   = 1'b0;

    if (rx_valid && rx_ready) begin
      rx_valid_nx = 1'b0;
    end

    if (stop_now) begin
      state_nx     = ST_IDLE;
      bit_cnt_nx   = '0;
      sda_low_nx   = 1'b0;
      scl_low_nx   = 1'b0;
      addressed_nx = 1'b0;
      stop_det_nx  = 1'b1;
    end else if (start_det) begin
      state_nx     = ST_ADDR;
      bit_cnt_nx   = '0;
      sda_low_nx   = 1'b0;
      scl_low_nx   = 1'b0;
      addressed_nx = 1'b0;
    end else begin
      case (state)
        ST_ADDR: begin
          if (scl_rise) begin
            shreg_nx   = {shreg[6:0], sda_s};
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall && bit_cnt == 4'd8) begin
            bit_cnt_nx = '0;
            if (addr_match(shreg, ADDR)) begin
              rw_nx        = shreg[0];
              sda_low_nx   = 1'b1;
              addressed_nx = 1'b1;
              state_nx     = ST_ADDR_ACK;
            end else begin
              state_nx = ST_IGNORE;
            end
          end
        end

        ST_ADDR_ACK: begin
          if (scl_rise) begin
            bit_cnt_nx = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_nx = '0;
            sda_low_nx = 1'b0;
            if (rw) begin
              scl_low_nx = 1'b1;
              state_nx   = ST_RD_LOAD;
            end else begin
              state_nx = ST_WR_BYTE;
            end
          end
        end

        // Once a full byte is in, SCL stays stretched until the previous
        // byte has been taken (or is being taken in this same cycle).
        ST_WR_BYTE: begin
          if (bit_cnt == 4'd8 && (scl_fall || scl_low)) begin
            if (!rx_valid || rx_ready) begin
              rx_data_nx  = shreg;
              rx_valid_nx = 1'b1;
              scl_low_nx  = 1'b0;
              sda_low_nx  = 1'b1;
              bit_cnt_nx  = '0;
              state_nx    = ST_WR_ACK;
            end else begin
              scl_low_nx = 1'b1;
            end
          end else if (scl_rise) begin
            shreg_nx   = {shreg[6:0], sda_s};
            bit_cnt_nx = bit_cnt + 4'd1;
          end
        end

        ST_WR_ACK: begin
          if (scl_rise) begin
            bit_cnt_nx = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_nx = '0;
            sda_low_nx = 1'b0;
            state_nx   = ST_WR_BYTE;
          end
        end

        // SCL is held low here; the first data bit goes onto SDA in the
        // same cycle SCL is let go.
        ST_RD_LOAD: begin
          scl_low_nx = 1'b1;
          if (tx_valid) begin
            tx_ready_nx = 1'b1;
            shreg_nx    = tx_data;
            sda_low_nx  = ~tx_data[7];
            scl_low_nx  = 1'b0;
            bit_cnt_nx  = '0;
            state_nx    = ST_RD_BYTE;
          end
        end

        ST_RD_BYTE: begin
          if (scl_rise) begin
            bit_cnt_nx = bit_cnt + 4'd1;
          end else if (scl_fall) begin
            if (bit_cnt == 4'd8) begin
              bit_cnt_nx = '0;
              sda_low_nx = 1'b0;
              state_nx   = ST_RD_ACK;
            end else begin
              shreg_nx   = {shreg[6:0], 1'b0};
              sda_low_nx = ~shreg[6];
            end
          end
        end

        ST_RD_ACK: begin
          if (scl_rise) begin
            master_ack_nx = (sda_s == I2C_ACK);
            bit_cnt_nx    = 4'd1;
          end else if (scl_fall && bit_cnt == 4'd1) begin
            bit_cnt_nx = '0;
            if (master_ack) begin
              scl_low_nx = 1'b1;
              state_nx   = ST_RD_LOAD;
            end else begin
              state_nx = ST_IGNORE;
            end
          end
        end

        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_target.sv
// Self-checking bench for i2c_target.
// The bench plays the I2C controller bit by bit on a wired-AND bus model,
// supplies/consumes bytes on the local handshakes with random timing, and
// compares what crosses the bus against what it intended to transfer.
module tb_i2c_target;

  localparam int         HALF  = 6;
  localparam logic [6:0] TADDR = 7'h18;
  localparam int         WAIT_LIMIT = 4000;

  typedef logic [7:0] byte_q_t[$];

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       ctrl_sda_low = 1'b0;
  logic       ctrl_scl_low = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic       rw;
  logic       addressed;
  logic       master_ack;
  logic       stop_det;

  int total = 0;
  int bad = 0;
  int tx_pulses = 0;
  int stop_pulses = 0;
  logic sda_ever_low = 1'b0;
  logic rx_hold = 1'b0;
  byte_q_t rx_got;
  byte_q_t tx_sent;

  i2c_if bus();

  assign bus.sda = ~(ctrl_sda_low | bus.sda_drive_low);
  assign bus.scl = ~(ctrl_scl_low | bus.scl_drive_low);

  i2c_target #(.ADDR(TADDR), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .i2c        (bus),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .tx_data    (tx_data),
    .tx_valid   (tx_valid),
    .tx_ready   (tx_ready),
    .rw         (rw),
    .addressed  (addressed),
    .master_ack (master_ack),
    .stop_det   (stop_det)
  );

  always #5 clk = ~clk;

  // Local-side agent: random rx_ready/tx_valid, records every byte handed
  // over in either direction and counts handshake/STOP pulses.
  initial begin
    tx_data = 8'($urandom);
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (tx_ready) begin
          tx_sent.push_back(tx_data);
          tx_pulses++;
          tx_data = 8'($urandom);
        end
        tx_valid = ($urandom_range(0, 3) != 0);
        rx_ready = rx_hold ? 1'b0 : ($urandom_range(0, 2) != 0);
        if (rx_valid && rx_ready) rx_got.push_back(rx_data);
        if (stop_det) stop_pulses++;
        if (bus.sda_drive_low) sda_ever_low = 1'b1;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Let SCL go and wait for the bus to follow (target may stretch).
  task automatic scl_release();
    int n;
    ctrl_scl_low = 1'b0;
    #1;
    n = 0;
    while (!bus.scl && n < WAIT_LIMIT) begin
      @(negedge clk);
      n++;
    end
    if (n >= WAIT_LIMIT) checkOutput("scl_release_timeout", 1, 0);
  endtask

  task automatic send_bit(input logic b);
    ctrl_sda_low = ~b;
    wait_clk(HALF);
    scl_release();
    wait_clk(HALF);
    ctrl_scl_low = 1'b1;
    wait_clk(1);
  endtask

  task automatic recv_bit(output logic b);
    ctrl_sda_low = 1'b0;
    wait_clk(HALF);
    scl_release();
    wait_clk(HALF / 2);
    b = bus.sda;
    wait_clk(HALF - HALF / 2);
    ctrl_scl_low = 1'b1;
    wait_clk(1);
  endtask

  task automatic send_byte(input logic [7:0] d, output logic acked);
    logic b;
    for (int i = 7; i >= 0; i--) send_bit(d[i]);
    recv_bit(b);
    acked = (b == 1'b0);
  endtask

  task automatic recv_byte(output logic [7:0] d, input logic ack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(~ack);
  endtask

  // Works both from an idle bus and as a repeated START with SCL low.
  task automatic do_start();
    ctrl_sda_low = 1'b0;
    wait_clk(HALF);
    scl_release();
    wait_clk(HALF);
    ctrl_sda_low = 1'b1;
    wait_clk(HALF);
    ctrl_scl_low = 1'b1;
    wait_clk(1);
  endtask

  task automatic do_stop();
    ctrl_sda_low = 1'b1;
    wait_clk(HALF);
    scl_release();
    wait_clk(HALF);
    ctrl_sda_low = 1'b0;
    wait_clk(HALF);
  endtask

  task automatic drain_rx();
    int n;
    n = 0;
    while (rx_valid && n < 400) begin
      wait_clk(1);
      n++;
    end
    checkOutput("rx_drained", rx_valid, 0);
  endtask

  // One complete write transfer; the target should accept it only when
  // the address byte is ours with the write flag.
  task automatic applyStimulus(input logic [7:0] addr_byte, input byte_q_t data);
    logic acked;
    logic hit;
    int   stops0;
    hit = (addr_byte[7:1] == TADDR) && !addr_byte[0];
    rx_got.delete();
    sda_ever_low = 1'b0;
    stops0 = stop_pulses;
    do_start();
    send_byte(addr_byte, acked);
    checkOutput("addr_ack", acked, hit);
    checkOutput("addressed", addressed, hit);
    if (hit) checkOutput("rw_write", rw, 0);
    foreach (data[i]) begin
      send_byte(data[i], acked);
      checkOutput("data_ack", acked, hit);
    end
    do_stop();
    wait_clk(4);
    checkOutput("stop_pulse", stop_pulses - stops0, 1);
    checkOutput("addressed_after_stop", addressed, 0);
    drain_rx();
    if (hit) begin
      checkOutput("rx_count", rx_got.size(), data.size());
      foreach (data[i])
        if (i < rx_got.size()) checkOutput("rx_byte", rx_got[i], data[i]);
    end else begin
      checkOutput("rx_count_ignored", rx_got.size(), 0);
      checkOutput("sda_never_driven", sda_ever_low, 0);
    end
  endtask

  // Read n bytes, ACK all but the last.
  task automatic read_transaction(input int n);
    logic       acked;
    logic [7:0] d;
    byte_q_t    got;
    int         tx0;
    int         stops0;
    tx_sent.delete();
    tx0 = tx_pulses;
    stops0 = stop_pulses;
    do_start();
    send_byte({TADDR, 1'b1}, acked);
    checkOutput("rd_addr_ack", acked, 1);
    checkOutput("rw_read", rw, 1);
    checkOutput("rd_addressed", addressed, 1);
    for (int i = 0; i < n; i++) begin
      recv_byte(d, i != n - 1);
      got.push_back(d);
    end
    do_stop();
    wait_clk(40);
    checkOutput("tx_ready_count", tx_pulses - tx0, n);
    checkOutput("rd_stop_pulse", stop_pulses - stops0, 1);
    checkOutput("master_ack_final", master_ack, 0);
    foreach (got[i])
      if (i < tx_sent.size()) checkOutput("rd_byte", got[i], tx_sent[i]);
  endtask

  task automatic check_reset_outputs(input string tag);
    checkOutput({tag, "_sda"}, bus.sda_drive_low, 0);
    checkOutput({tag, "_scl"}, bus.scl_drive_low, 0);
    checkOutput({tag, "_rx_data"}, rx_data, 0);
    checkOutput({tag, "_rx_valid"}, rx_valid, 0);
    checkOutput({tag, "_tx_ready"}, tx_ready, 0);
    checkOutput({tag, "_rw"}, rw, 0);
    checkOutput({tag, "_addressed"}, addressed, 0);
    checkOutput({tag, "_master_ack"}, master_ack, 0);
    checkOutput({tag, "_stop_det"}, stop_det, 0);
  endtask

  initial begin
    byte_q_t    q;
    logic       acked;
    logic [7:0] d;
    logic [7:0] r;
    logic [6:0] a;
    int         n;

    rstn = 1'b0;
    wait_clk(5);
    check_reset_outputs("reset");
    rstn = 1'b1;
    wait_clk(10);
    check_reset_outputs("post_reset");

    $display("[TB] fixed write 0x30 12 32 99");
    q = '{8'h12, 8'h32, 8'h99};
    applyStimulus(8'h30, q);

    $display("[TB] address mismatch 0x34");
    q = '{8'($urandom), 8'($urandom), 8'($urandom)};
    applyStimulus(8'h34, q);

    $display("[TB] read 3 bytes");
    read_transaction(3);

    $display("[TB] random transfers");
    for (int k = 0; k < 8; k++) begin
      q.delete();
      n = $urandom_range(1, 4);
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
      case ($urandom_range(0, 2))
        0: applyStimulus({TADDR, 1'b0}, q);
        1: begin
          a = 7'($urandom);
          if (a == TADDR) a = a ^ 7'h01;
          applyStimulus({a, 1'($urandom)}, q);
        end
        default: read_transaction(n);
      endcase
    end

    $display("[TB] stretch while rx_valid pending");
    rx_hold = 1'b1;
    q = '{8'h12, 8'h32};
    fork
      applyStimulus(8'h30, q);
      begin
        n = 0;
        while (!rx_valid && n < WAIT_LIMIT) begin
          wait_clk(1);
          n++;
        end
        checkOutput("stretch_first_byte", rx_valid, 1);
        wait_clk(250);
        checkOutput("stretch_scl_held", bus.scl_drive_low, 1);
        checkOutput("stretch_bus_scl", bus.scl, 0);
        rx_hold = 1'b0;
      end
    join

    $display("[TB] write then repeated START read");
    rx_got.delete();
    tx_sent.delete();
    d = 8'($urandom);
    do_start();
    send_byte(8'h30, acked);
    checkOutput("rs_wr_addr_ack", acked, 1);
    send_byte(d, acked);
    checkOutput("rs_wr_data_ack", acked, 1);
    checkOutput("rs_rw_before", rw, 0);
    do_start();
    send_byte(8'h31, acked);
    checkOutput("rs_rd_addr_ack", acked, 1);
    checkOutput("rs_rw_after", rw, 1);
    checkOutput("rs_addressed", addressed, 1);
    recv_byte(r, 1'b0);
    do_stop();
    wait_clk(20);
    drain_rx();
    checkOutput("rs_tx_count", tx_sent.size(), 1);
    if (tx_sent.size() > 0) checkOutput("rs_rd_byte", r, tx_sent[0]);
    checkOutput("rs_rx_count", rx_got.size(), 1);
    if (rx_got.size() > 0) checkOutput("rs_rx_byte", rx_got[0], d);

    $display("[TB] reset in the middle of a read byte");
    do_start();
    send_byte(8'h31, acked);
    checkOutput("mid_addr_ack", acked, 1);
    for (int i = 0; i < 3; i++) recv_bit(r[0]);
    rstn = 1'b0;
    #1;
    check_reset_outputs("mid_reset");
    ctrl_scl_low = 1'b0;
    ctrl_sda_low = 1'b0;
    wait_clk(5);
    rstn = 1'b1;
    wait_clk(20);
    q = '{8'h77};
    applyStimulus(8'h30, q);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global watchdog so the run always ends with a summary.
  initial begin
    #2000000;
    checkOutput("global_timeout", 1, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/i2c_target.md
Name: i2c_target

Overview:
- Synchronous, oversampled I2C target (slave) that forms the responder end of the bus driven by i2c_ctrl.
- Detects START, repeated START and STOP, and matches a 7-bit address. On writes it shifts bytes in; on reads it shifts bytes out.
- Hands bytes to and from local logic via valid/ready handshakes.
- Stretches SCL when local logic is not ready. Used as on-chip peripheral front end and as a synthesizable bench partner for i2c_ctrl.

Parameters:
- ADDR, 7'h18, 7-bit target address (bus byte 0x30 write / 0x31 read).
- SYNC_STAGES, 2, synchronizer flops on sda/scl inputs (min 2).

Ports:
- clk  input  1  system clock
- rstn  input  1  asynchronous active-low reset
- i2c  interface  i2c_if  open-drain sda/scl; block only drives 0 or Z, never 1
- rx_data  output  8  received write byte
- rx_valid  output  1  rx_data holds an unconsumed byte
- rx_ready  input  1  consumer takes rx_data when rx_valid&&rx_ready
- tx_data  input  8  byte to send on read
- tx_valid  input  1  tx_data available
- tx_ready  output  1  one-cycle pulse: tx_data captured
- rw  output  1  R/W bit of current addressed transaction
- addressed  output  1  high from address ACK until STOP/repeated START
- master_ack  output  1  last ACK bit from controller after a read byte (1=ACK)
- stop_det  output  1  one-cycle pulse on any STOP

Behaviour:
- Reset (async, rstn=0):
  - sda/scl released (Z); state IDLE.
  - rx_data=0, rx_valid=0, tx_ready=0, rw=0, addressed=0, master_ack=0, stop_det=0.
  - Reset mid-transfer releases lines immediately.
- Input handling:
  - sda/scl pass through SYNC_STAGES flops, then a 1-flop history for edge detection.
  - START = sda fall while scl high; STOP = sda rise while scl high.
  - Supports SCL high and low phases of ≥4 clk each (i2c_ctrl CLK_DIV=10 satisfies this).
- Bit timing:
  - Bits are sampled on the synced scl rising edge.
  - sda output changes only on the synced scl falling edge (sync delay provides hold time).
- States: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_LOAD, RD_BYTE, RD_ACK, IGNORE.
- START or repeated START, from any state: go to ADDR, bit counter=0, release sda, addressed=0.
- STOP, from any state: go to IDLE, release sda/scl, addressed=0, stop_det=1 for one cycle. STOP takes priority over a same-cycle START.
- ADDR: shift 8 bits MSB first.
  - bits[7:1]==ADDR: latch rw=bit0, go to ADDR_ACK.
  - Otherwise: go to IGNORE, sda never driven, until START/STOP.
- ADDR_ACK:
  - Drive sda=0 from the falling edge after bit 8 until the falling edge after the 9th clock; set addressed=1.
  - Then go to WR_BYTE (rw=0) or RD_LOAD (rw=1).
- WR_BYTE: shift 8 bits.
  - On the falling edge after bit 8, if rx_valid is still 1, hold scl=0 (stretch) until it clears.
  - Then load rx_data, set rx_valid=1, go to WR_ACK and drive ACK (sda=0) for the 9th clock, then return to WR_BYTE.
  - rx_valid clears on rx_valid&&rx_ready. Same-cycle consume and new load: rx_valid stays 1 with the new data.
- RD_LOAD:
  - Holds scl=0 until tx_valid=1.
  - Then pulses tx_ready, captures tx_data, releases scl, goes to RD_BYTE.
- RD_BYTE: drive each bit MSB first (0 → drive low, 1 → Z); after 8 clocks release sda and go to RD_ACK.
- RD_ACK: sample the controller's ACK on the 9th rising edge into master_ack.
  - ACK: go to RD_LOAD.
  - NAK: go to IGNORE; no further tx_ready.
- Bit counter is 4 bits, 0..8, cleared on START and after each ACK slot.

Decomposition:
- Package i2c_target_pkg: state_t enum (above), constant I2C_ACK=1'b0, I2C_NAK=1'b1.
- Sub-module i2c_line_sync: parameterized synchronizer plus rise/fall detect for one line. Instantiated twice (sda, scl); START/STOP derived in the parent.

Test Plan:
- Write 0x30 + 12,32,99, rx_ready tied 1 → rx_valid pulses with 0x12,0x32,0x99 in order; controller sees ACK on all 4 bytes; rw=0; stop_det pulse at end.
- Address 0x34 (mismatch), 3 data bytes → controller gets NAK on the address; rx_valid never asserted; sda never driven low; addressed=0.
- Read 0x31, tx supplies 00,ff,ac, controller ACK,ACK,NAK → controller receives 00,ff,ac; tx_ready pulses exactly 3; master_ack ends at 0; no 4th tx_ready.
- Write 0x30 + 12,32, rx_ready=0 until 50 clk after the first byte → scl held low after the second byte until rx_ready=1; second byte 0x32 delivered intact.
- Write 0x30 + 0x55, repeated START, read 0x31 with tx=0xa5 → rw changes 0→1; addressed held; read returns 0xa5.
- rstn pulsed low in the middle of a read byte → sda/scl released within the reset cycle; all outputs 0. The next transaction (write 0x30 + 0x77) completes correctly.
